// File: rtl/exp6_mostrador_sequencia.sv
// Sequence presenter: walks the sequence ROM from entry 0 up to the current
// round, lighting each word on the LEDs for T_ACESO cycles then blanking T_APAGADO.
module exp6_mostrador_sequencia #(
    parameter int T_ACESO   = 500,
    parameter int T_APAGADO = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       cancelar,
    input  logic [3:0] rodada,
    input  logic [3:0] dado_mem,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       mostrando,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ESPERA  = 3'd2,
        ACESO   = 3'd3,
        APAGADO = 3'd4,
        PROXIMO = 3'd5,
        FIM     = 3'd6
    } estado_t;

    localparam int T_MAX = (T_ACESO > T_APAGADO) ? T_ACESO : T_APAGADO;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] LIM_ACESO   = TW'(T_ACESO - 1);
    localparam logic [TW-1:0] LIM_APAGADO = TW'(T_APAGADO - 1);

    estado_t       estado;
    estado_t       proximo;
    logic [TW-1:0] timer;
    logic [3:0]    rodada_reg;
    logic          fim_aceso;
    logic          fim_apagado;
    logic          ultimo;

    assign fim_aceso   = (timer == LIM_ACESO);
    assign fim_apagado = (timer == LIM_APAGADO);
    assign ultimo      = (endereco == rodada_reg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    // cancelar overrides every transition, including an accept in OCIOSO
    always_comb begin
        proximo = estado;
        if (cancelar) begin
            proximo = OCIOSO;
        end else begin
            unique case (estado)
                OCIOSO:  if (iniciar) proximo = CARREGA;
                CARREGA: proximo = ESPERA;
                ESPERA:  proximo = ACESO;
                ACESO:   if (fim_aceso) proximo = APAGADO;
                APAGADO: if (fim_apagado) proximo = PROXIMO;
                PROXIMO: proximo = ultimo ? FIM : CARREGA;
                FIM:     proximo = OCIOSO;
                default: proximo = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco   <= 4'd0;
            leds       <= 4'd0;
            timer      <= '0;
            rodada_reg <= 4'd0;
        end else if (cancelar) begin
            endereco <= 4'd0;
            leds     <= 4'd0;
            timer    <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    endereco <= 4'd0;
                    leds     <= 4'd0;
                    timer    <= '0;
                    if (iniciar) rodada_reg <= rodada;
                end
                ESPERA: begin
                    leds  <= dado_mem;
                    timer <= '0;
                end
                ACESO: begin
                    if (fim_aceso) begin
                        leds  <= 4'd0;
                        timer <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                APAGADO: begin
                    if (fim_apagado) timer <= '0;
                    else timer <= timer + 1'b1;
                end
                PROXIMO: begin
                    if (!ultimo) endereco <= endereco + 4'd1;
                end
                FIM: begin
                    endereco <= 4'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign mostrando = (estado != OCIOSO) && (estado != FIM);
    assign pronto    = (estado == FIM);
    assign db_estado = {1'b0, estado};

endmodule

// File: tb/tb_exp6_mostrador_sequencia.sv
// Directed bench for the sequence presenter with a synchronous ROM model
// holding 1,2,4,8 repeating; T_ACESO=4, T_APAGADO=2, so each entry lasts 9 cycles.
module tb_exp6_mostrador_sequencia;

    localparam int TA = 4;
    localparam int TB = 2;
    localparam int P  = TA + TB + 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       cancelar = 1'b0;
    logic [3:0] rodada = 4'd0;
    logic [3:0] dado_mem;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       mostrando;
    logic       pronto;
    logic [3:0] db_estado;

    logic [3:0] rom [16];

    int n_checks = 0;
    int n_pass   = 0;

    exp6_mostrador_sequencia #(
        .T_ACESO  (TA),
        .T_APAGADO(TB)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .cancelar (cancelar),
        .rodada   (rodada),
        .dado_mem (dado_mem),
        .endereco (endereco),
        .leds     (leds),
        .mostrando(mostrando),
        .pronto   (pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'(1 << (i % 4));
    end

    always_ff @(posedge clock) dado_mem <= rom[endereco];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".leds"}, 32'(leds), 0);
        check({tag, ".end"}, 32'(endereco), 0);
        check({tag, ".most"}, 32'(mostrando), 0);
        check({tag, ".pronto"}, 32'(pronto), 0);
        check({tag, ".est"}, 32'(db_estado), 0);
    endtask

    task automatic start(input int r);
        @(negedge clock);
        rodada  = 4'(r);
        iniciar = 1'b1;
    endtask

    task automatic run(input int r, input int cancel_at, input int noise_at);
        int last;
        int e;
        int off;
        int em, ep, ee, el, es;
        last = (r + 1) * P + 2;
        start(r);
        for (int n = 1; n <= last; n++) begin
            @(negedge clock);
            if (n == 1) iniciar = 1'b0;
            if (cancel_at > 0 && n == cancel_at + 1) begin
                check_idle($sformatf("cancel@%0d", n));
                cancelar = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    check($sformatf("post_cancel_pronto%0d", k), 32'(pronto), 0);
                    check($sformatf("post_cancel_est%0d", k), 32'(db_estado), 0);
                end
                return;
            end
            e   = (n - 1) / P;
            off = (n - 1) % P + 1;
            if (n <= (r + 1) * P) begin
                em = 1;
                ep = 0;
                ee = e;
                el = (off >= 3 && off <= 2 + TA) ? (1 << (e % 4)) : 0;
                if (off == 1) es = 1;
                else if (off == 2) es = 2;
                else if (off <= 2 + TA) es = 3;
                else if (off <= 2 + TA + TB) es = 4;
                else es = 5;
            end else if (n == (r + 1) * P + 1) begin
                em = 0; ep = 1; ee = r; el = 0; es = 6;
            end else begin
                em = 0; ep = 0; ee = 0; el = 0; es = 0;
            end
            check($sformatf("r%0d.leds@%0d", r, n), 32'(leds), 32'(el));
            check($sformatf("r%0d.end@%0d", r, n), 32'(endereco), 32'(ee));
            check($sformatf("r%0d.most@%0d", r, n), 32'(mostrando), 32'(em));
            check($sformatf("r%0d.pronto@%0d", r, n), 32'(pronto), 32'(ep));
            check($sformatf("r%0d.est@%0d", r, n), 32'(db_estado), 32'(es));
            if (n == cancel_at) cancelar = 1'b1;
            if (n == noise_at) begin
                iniciar = 1'b1;
                rodada  = 4'd5;
            end
            if (noise_at > 0 && n == noise_at + 1) iniciar = 1'b0;
        end
    endtask

    initial begin
        // power-on reset
        @(negedge clock);
        check_idle("por");
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_idle("idle");
        end

        // asynchronous reset while an entry is lit
        start(2);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clock);
            if (n == 1) iniciar = 1'b0;
        end
        check("pre_rst.leds", 32'(leds), 1);
        check("pre_rst.est", 32'(db_estado), 3);
        reset = 1'b0;
        #1;
        check_idle("async_rst");
        @(negedge clock);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_idle("after_rst");
        end

        run(0, 0, 0);
        run(2, 0, 0);
        run(15, 0, 0);
        run(2, 14, 0);
        run(0, 0, 0);
        run(2, 0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
